uart_rx_dec: RTL
================

# uart_rx_dec

Serial receiver paired with the (7,4) transmit chain. It consumes the one-bit-per-clock frame produced by the transmit shifter: start bit 0, seven codeword bits LSB first, stop bit 1. It deserialises the codeword, computes the Hamming syndrome and corrects any single-bit error, then undoes the NOT encryption. It presents the recovered 4-bit nibble with a one-cycle valid strobe for the board LEDs and downstream logic.

## Interface
- N, 7, codeword length; only 7 is supported.
- K, 4, data width; only 4 is supported.
- clk  in  1  system clock; one line bit per cycle, with no baud divider.
- rst  in  1  synchronous, active-high reset.
- data_in  in  1  serial line from the transmitter's data_out.
- frame_sync  in  1  high for exactly the cycle in which the start bit is on data_in (transmitter load delayed one register).
- data_out  out  K  decoded, decrypted nibble; holds its value until the next valid frame.
- data_valid  out  1  one-cycle pulse; data_out is new.
- err_corrected  out  1  qualified by data_valid; a non-zero syndrome was corrected.
- syndrome  out  3  {s2,s1,s0} of the last accepted frame; for LEDs.
- frame_err  out  1  one-cycle pulse on a bad start or stop bit.
- busy  out  1  high while in DATA or STOP.

## Operation
- States:
  - IDLE: wait for frame_sync.
  - DATA: shift in 7 bits.
  - STOP: check the stop bit.
- IDLE with frame_sync=1:
  - data_in=0: go to DATA, bit count=0.
  - data_in=1: pulse frame_err and stay in IDLE.
  - frame_sync=0: ignore data_in.
- DATA:
  - Each cycle, store data_in into r[count], then increment count.
  - After count=6, go to STOP.
  - First received bit is r[0].
- STOP:
  - data_in=1: register the decode result, pulse data_valid, go to IDLE.
  - data_in=0: pulse frame_err, leave data_out and syndrome unchanged, go to IDLE.
- frame_sync in DATA or STOP is ignored; the frame in progress completes.
- Codeword layout: r[6:3] = encrypted data d[3:0]; r[2:0] = parity.
- Syndrome:
  - s2 = r2^r6^r5^r4
  - s1 = r1^r6^r4^r3
  - s0 = r0^r6^r5^r3
- Syndrome-to-bit map (flip that bit):
  - 111→bit6, 101→bit5, 110→bit4, 011→bit3
  - 100→bit2, 010→bit1, 001→bit0
  - 000→no flip
- data_out = ~corrected[6:3].
- err_corrected = (syndrome != 0).
- Double-bit errors are miscorrected silently. This is an accepted limitation of the code.

## Timing
- Cycle 0: start bit, with frame_sync.
- Cycles 1–7: codeword bits.
- Cycle 8: stop bit.
- data_valid, data_out and syndrome update on the clock edge that ends cycle 8. They are visible in cycle 9.
- frame_err for a bad stop bit is visible in cycle 9. For a bad start bit it is visible in cycle 1.
- Back-to-back frames: a frame_sync in cycle 9 is accepted, because the FSM is back in IDLE.
- Reset: state=IDLE, count=0, r=0. All outputs are 0: data_out, data_valid, err_corrected, syndrome, frame_err and busy.
- Reset mid-frame aborts the frame; no data_valid and no frame_err are produced.
- All outputs are registered.

## Structure
- Shared package: state encoding (IDLE/DATA/STOP), the syndrome-to-position constants, and the start/stop bit values.
- One natural sub-module: hamming74_dec, purely combinational. It maps r[6:0] to corrected[6:0] and syndrome[2:0]. It mirrors the transmitter's encoder, so it can also be checked on its own in a loopback bench against that encoder.

## Test plan
- Clean frame: transmitter input 4'b0101 gives encrypted 1010 and codeword 7'b1010001. Line sequence 0,1,0,0,0,1,0,1,1 with frame_sync in cycle 0. Required: data_out=0101, data_valid pulse in cycle 9, syndrome=000, err_corrected=0.
- Single error: same frame with r4 inverted. Required: syndrome=110, err_corrected=1, data_out=0101.
- Parity-bit error: same frame with r0 inverted. Required: syndrome=001, data_out=0101.
- Bad stop bit: stop bit=0. Required: frame_err pulse in cycle 9, no data_valid, data_out keeps its previous value.
- Bad start bit and sync behaviour:
  - frame_sync while data_in=1 → frame_err in cycle 1, FSM stays in IDLE.
  - frame_sync pulsed in cycle 4 of a frame → ignored; the frame decodes correctly.
- Reset and back-to-back:
  - rst asserted in cycle 5 → no outputs asserted, all outputs read 0.
  - Two frames back-to-back (4'b0000 then 4'b1111, second frame_sync in cycle 9) → two data_valid pulses with data_out 0000 then 1111.

Source files
------------

// File: rtl/uart_rx_dec_pkg.sv
// Shared definitions for the (7,4) Hamming serial receiver: FSM state
// encoding, frame bit values, codeword geometry and the syndrome-to-bit map.
package uart_rx_dec_pkg;

  // Codeword / data geometry. Only the (7,4) code is implemented.
  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;
  localparam int CNT_W  = 3;

  // Index of the last codeword bit shifted in before the stop bit.
  localparam logic [CNT_W-1:0] LAST_BIT_IDX = 3'd6;

  // Line levels framing each codeword.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Syndrome {s2,s1,s0} produced by a single error in each codeword bit.
  localparam logic [SYN_W-1:0] SYN_NONE = 3'b000;
  localparam logic [SYN_W-1:0] SYN_BIT6 = 3'b111;
  localparam logic [SYN_W-1:0] SYN_BIT5 = 3'b101;
  localparam logic [SYN_W-1:0] SYN_BIT4 = 3'b110;
  localparam logic [SYN_W-1:0] SYN_BIT3 = 3'b011;
  localparam logic [SYN_W-1:0] SYN_BIT2 = 3'b100;
  localparam logic [SYN_W-1:0] SYN_BIT1 = 3'b010;
  localparam logic [SYN_W-1:0] SYN_BIT0 = 3'b001;

  // One-hot mask of the codeword bit a given syndrome points at.
  function automatic logic [CW_W-1:0] syn_flip_mask(input logic [SYN_W-1:0] syn);
    logic [CW_W-1:0] mask;
    // NOTE: give every combinationally computed variable a value before any
    // branching; a path that leaves it unassigned would infer a latch.
    mask = '0;
    case (syn)
      SYN_BIT6: mask = 7'b100_0000;
      SYN_BIT5: mask = 7'b010_0000;
      SYN_BIT4: mask = 7'b001_0000;
      SYN_BIT3: mask = 7'b000_1000;
      SYN_BIT2: mask = 7'b000_0100;
      SYN_BIT1: mask = 7'b000_0010;
      SYN_BIT0: mask = 7'b000_0001;
      SYN_NONE: mask = 7'b000_0000;
      default:  mask = 7'b000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/uart_rx_dec_hamming74_dec.sv
// Combinational (7,4) Hamming decoder. Computes the syndrome of a received
// codeword and flips the single bit it identifies. Mirrors the transmitter's
// encoder: r[6:3] are data bits, r[2:0] are the parity bits.
module hamming74_dec
  import uart_rx_dec_pkg::*;
(
  input  logic [CW_W-1:0]  r_i,
  output logic [CW_W-1:0]  corrected_o,
  output logic [SYN_W-1:0] syndrome_o
);

  logic [SYN_W-1:0] syn;

  // Parity checks, then correction of the bit the syndrome points at.
  always_comb begin
    syn[2]      = r_i[2] ^ r_i[6] ^ r_i[5] ^ r_i[4];
    syn[1]      = r_i[1] ^ r_i[6] ^ r_i[4] ^ r_i[3];
    syn[0]      = r_i[0] ^ r_i[6] ^ r_i[5] ^ r_i[3];
    corrected_o = r_i ^ syn_flip_mask(syn);
    syndrome_o  = syn;
  end

endmodule

// File: rtl/uart_rx_dec.sv
// Serial receiver for the (7,4) Hamming transmit chain. One line bit per
// clock: start bit (0), seven codeword bits LSB first, stop bit (1). The
// codeword is deserialised, single-bit errors are corrected and the NOT
// encryption is removed. All outputs are registered.
module uart_rx_dec
  import uart_rx_dec_pkg::*;
#(
  parameter int N = CW_W,    // codeword length, only 7 is supported
  parameter int K = DATA_W   // data width, only 4 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             frame_sync,
  output logic [K-1:0]     data_out,
  output logic             data_valid,
  output logic             err_corrected,
  output logic [SYN_W-1:0] syndrome,
  output logic             frame_err,
  output logic             busy
);

  // FSM and frame buffer.
  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [N-1:0]     r_q;

  // Registered outputs.
  logic [K-1:0]     data_q;
  logic             valid_q;
  logic             err_corr_q;
  logic [SYN_W-1:0] syn_q;
  logic             frame_err_q;
  logic             busy_q;

  // Decode results, loaded into the output registers on a good stop bit.
  logic [N-1:0]     dec_corrected;
  logic [SYN_W-1:0] dec_syn_d;
  logic [K-1:0]     dec_data_d;
  logic             dec_err_d;

  // The buffer is complete by the time the FSM sits in STOP, so the decoder
  // works straight off r_q and its result is ready for the stop-bit edge.
  hamming74_dec u_dec (
    .r_i         (r_q),
    .corrected_o (dec_corrected),
    .syndrome_o  (dec_syn_d)
  );

  assign dec_data_d = ~dec_corrected[N-1:N-K];
  assign dec_err_d  = (dec_syn_d != SYN_NONE);

  // Parity bits of the corrected word carry no payload.
  logic unused_parity;
  assign unused_parity = ^dec_corrected[N-K-1:0];

  // Frame FSM: start check, bit collection, stop check and output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the seven-bit frame buffer is reset along with the FSM so the
      // decoder never sees an undefined codeword after reset.
      state_q     <= ST_IDLE;
      count_q     <= '0;
      r_q         <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_corr_q  <= 1'b0;
      syn_q       <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: state is updated with <= only, so every register samples the
      // pre-edge values no matter how the statements below are ordered.
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (frame_sync) begin
            if (data_in == START_BIT) begin
              state_q <= ST_DATA;
              count_q <= '0;
              busy_q  <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        ST_DATA: begin
          r_q[count_q] <= data_in;
          if (count_q == LAST_BIT_IDX) begin
            state_q <= ST_STOP;
            count_q <= '0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        ST_STOP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (data_in == STOP_BIT) begin
            data_q     <= dec_data_d;
            syn_q      <= dec_syn_d;
            err_corr_q <= dec_err_d;
            valid_q    <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign err_corrected = err_corr_q;
  assign syndrome      = syn_q;
  assign frame_err     = frame_err_q;
  assign busy          = busy_q;

endmodule
